// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: hazard and forwarding controller between decode and execute
// of the in-order pipeline.
//
// It tracks in-flight register writers in post-decode slots. Slot 0 is X and
// slot 1 is M at the default depth. From these it computes the load-use and
// multi-cycle stall, and the registered per-operand forwarding selects.
//
// Optional feature: define HAZ_PERF_CNT_EN to build the saturating stall-cycle
// counter. Without it, stall_cycles is tied to zero.
//
// Parameter constraints: STAGES >= 2 and 2**SEL_W > STAGES.
module hazard_scoreboard #(
    parameter int STAGES = 3,
    parameter int REG_AW = 5,
    parameter int SEL_W  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rs,
    input  logic              issue_rs_used,
    input  logic [REG_AW-1:0] issue_rt,
    input  logic              issue_rt_used,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_we,
    input  logic [SEL_W-1:0]  issue_rdy_stg,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel,
    output logic [15:0]       stall_cycles
);

    // The oldest slot (STAGES-1) is never matched, because the regfile is
    // write-through. Its content would only be shifted out, so only the
    // matchable slots 0..STAGES-2 are held in flops.
    localparam int NSLOT = STAGES - 1;

    logic [NSLOT-1:0]             r_slot_valid;
    logic [NSLOT-1:0]             r_slot_we;
    logic [NSLOT-1:0][REG_AW-1:0] r_slot_rd;
    logic [NSLOT-1:0][SEL_W-1:0]  r_slot_rdy;
    logic [SEL_W-1:0]             r_fwd_a_sel;
    logic [SEL_W-1:0]             r_fwd_b_sel;

    logic [SEL_W:0]               w_match_a;
    logic [SEL_W:0]               w_match_b;
    logic                         w_stall;
    logic                         w_accept;
    logic                         w_load_we;
    logic [REG_AW-1:0]            w_load_rd;
    logic [SEL_W-1:0]             w_load_rdy;

    // Youngest-writer lookup for one source operand.
    // Result: {needs_stall, forward_select}. A select of 0 means the regfile.
    // The scan runs from the oldest slot to the youngest, so the last hit wins
    // and older writers of the same register are shadowed.
    function automatic logic [SEL_W:0] f_match(
        input logic [REG_AW-1:0]             src,
        input logic                          used,
        input logic [NSLOT-1:0]              vld,
        input logic [NSLOT-1:0]              we,
        input logic [NSLOT-1:0][REG_AW-1:0]  rd,
        input logic [NSLOT-1:0][SEL_W-1:0]   rdy
    );
        logic [SEL_W-1:0] sel;
        logic             need;
        logic             hit;
        sel  = {SEL_W{1'b0}};
        need = 1'b0;
        for (int i = NSLOT - 1; i >= 0; i--) begin
            hit  = used && (src != {REG_AW{1'b0}}) && vld[i] && we[i] && (rd[i] == src);
            sel  = hit ? SEL_W'(i + 1) : sel;
            need = hit ? (rdy[i] > SEL_W'(i + 1)) : need;
        end
        return {need, sel};
    endfunction

    // Hazard evaluation. Flush has priority, so a squashed instruction never
    // stalls.
    always_comb begin
        w_match_a  = f_match(issue_rs, issue_rs_used, r_slot_valid, r_slot_we,
                             r_slot_rd, r_slot_rdy);
        w_match_b  = f_match(issue_rt, issue_rt_used, r_slot_valid, r_slot_we,
                             r_slot_rd, r_slot_rdy);
        w_stall    = issue_valid & ~flush & (w_match_a[SEL_W] | w_match_b[SEL_W]);
        w_accept   = issue_valid & ~flush & ~w_stall;
        w_load_we  = w_accept & issue_we;
        w_load_rd  = w_load_we ? issue_rd : {REG_AW{1'b0}};
        w_load_rdy = w_accept ? issue_rdy_stg : {SEL_W{1'b0}};
    end

    assign stall     = w_stall;
    assign fwd_a_sel = r_fwd_a_sel;
    assign fwd_b_sel = r_fwd_b_sel;

    // Slot shift register: an accepted issue enters slot 0, otherwise slot 0
    // takes a bubble. Older slots are never flushed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_valid <= {NSLOT{1'b0}};
            r_slot_we    <= {NSLOT{1'b0}};
            r_slot_rd    <= {(NSLOT*REG_AW){1'b0}};
            r_slot_rdy   <= {(NSLOT*SEL_W){1'b0}};
        end else begin
            for (int i = NSLOT - 1; i > 0; i--) begin
                r_slot_valid[i] <= r_slot_valid[i-1];
                r_slot_we[i]    <= r_slot_we[i-1];
                r_slot_rd[i]    <= r_slot_rd[i-1];
                r_slot_rdy[i]   <= r_slot_rdy[i-1];
            end
            r_slot_valid[0] <= w_accept;
            r_slot_we[0]    <= w_load_we;
            r_slot_rd[0]    <= w_load_rd;
            r_slot_rdy[0]   <= w_load_rdy;
        end
    end

    // Forwarding selects, registered so they are valid in the instruction's X
    // cycle. A bubble drives 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fwd_a_sel <= {SEL_W{1'b0}};
            r_fwd_b_sel <= {SEL_W{1'b0}};
        end else if (w_accept) begin
            r_fwd_a_sel <= w_match_a[SEL_W-1:0];
            r_fwd_b_sel <= w_match_b[SEL_W-1:0];
        end else begin
            r_fwd_a_sel <= {SEL_W{1'b0}};
            r_fwd_b_sel <= {SEL_W{1'b0}};
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] r_stall_cycles;

    // Saturating stall-cycle counter. Only reset clears it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= 16'h0000;
        end else if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end else begin
            r_stall_cycles <= r_stall_cycles;
        end
    end

    assign stall_cycles = r_stall_cycles;
`else
    assign stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
// It drives the default-depth instance and a STAGES=5 instance.
module tb_hazard_scoreboard;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [31:0] EXP_CNT3 = 32'd3;
`else
    localparam logic [31:0] EXP_CNT3 = 32'd0;
`endif

    logic        clock;
    logic        reset_n;
    logic        issue_valid, issue_rs_used, issue_rt_used, issue_we, flush;
    logic [4:0]  issue_rs, issue_rt, issue_rd;
    logic [1:0]  issue_rdy_stg;
    logic        stall;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_cycles;

    logic        s5_valid, s5_rs_used, s5_rt_used, s5_we, s5_flush;
    logic [4:0]  s5_rs, s5_rt, s5_rd;
    logic [2:0]  s5_rdy;
    logic        s5_stall;
    logic [2:0]  s5_fwd_a, s5_fwd_b;
    logic [15:0] s5_cycles;

    int n_checks = 0;
    int n_errors = 0;

    hazard_scoreboard dut (
        .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid),
        .issue_rs(issue_rs), .issue_rs_used(issue_rs_used),
        .issue_rt(issue_rt), .issue_rt_used(issue_rt_used),
        .issue_rd(issue_rd), .issue_we(issue_we), .issue_rdy_stg(issue_rdy_stg),
        .flush(flush), .stall(stall), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall_cycles(stall_cycles)
    );

    hazard_scoreboard #(.STAGES(5), .REG_AW(5), .SEL_W(3)) dut5 (
        .clock(clock), .reset_n(reset_n), .issue_valid(s5_valid),
        .issue_rs(s5_rs), .issue_rs_used(s5_rs_used),
        .issue_rt(s5_rt), .issue_rt_used(s5_rt_used),
        .issue_rd(s5_rd), .issue_we(s5_we), .issue_rdy_stg(s5_rdy),
        .flush(s5_flush), .stall(s5_stall), .fwd_a_sel(s5_fwd_a),
        .fwd_b_sel(s5_fwd_b), .stall_cycles(s5_cycles)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_issue(input logic v, input logic [4:0] rs, input logic rsu,
                             input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                             input logic we, input logic [1:0] rdy, input logic fl);
        issue_valid = v; issue_rs = rs; issue_rs_used = rsu; issue_rt = rt;
        issue_rt_used = rtu; issue_rd = rd; issue_we = we; issue_rdy_stg = rdy;
        flush = fl;
    endtask

    task automatic idle(input int n);
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        set_issue(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
        s5_valid = 1'b0; s5_rs = 5'd0; s5_rs_used = 1'b0; s5_rt = 5'd0;
        s5_rt_used = 1'b0; s5_rd = 5'd0; s5_we = 1'b0; s5_rdy = 3'd0; s5_flush = 1'b0;
        #3;
        check_val("rst_stall", stall, 1'b0);
        check_val("rst_a", fwd_a_sel, 2'd0);
        check_val("rst_b", fwd_b_sel, 2'd0);
        check_val("rst_cnt", stall_cycles, 16'd0);
        #9 reset_n = 1'b1;
        tick();

        // ALU-to-ALU back-to-back: MX forwarding, no stall.
        set_issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 2'd1, 1'b0);
        #1 check_val("alu1_stall", stall, 1'b0);
        tick();
        set_issue(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 2'd1, 1'b0);
        #1 check_val("alu2_stall", stall, 1'b0);
        tick();
        check_val("alu_fwd_a", fwd_a_sel, 2'd1);
        check_val("alu_fwd_b", fwd_b_sel, 2'd0);
        idle(1);
        check_val("bubble_a", fwd_a_sel, 2'd0);
        idle(2);

        // Load-use: one stall cycle, then WX forwarding.
        set_issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'd2, 1'b0);
        #1 check_val("lw_stall", stall, 1'b0);
        tick();
        set_issue(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 2'd1, 1'b0);
        #1 check_val("lu_stall1", stall, 1'b1);
        tick();
        check_val("lu_bubble_a", fwd_a_sel, 2'd0);
        #1 check_val("lu_stall2", stall, 1'b0);
        tick();
        check_val("lu_fwd_a", fwd_a_sel, 2'd2);
        idle(3);

        // Shadowing: the youngest writer of r5 wins.
        set_issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 2'd1, 1'b0);
        tick();
        set_issue(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 2'd1, 1'b0);
        tick();
        set_issue(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 2'd1, 1'b0);
        #1 check_val("shd_stall", stall, 1'b0);
        tick();
        check_val("shd_a", fwd_a_sel, 2'd1);
        check_val("shd_b", fwd_b_sel, 2'd1);
        idle(3);

        // Register zero never matches.
        set_issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 2'd2, 1'b0);
        tick();
        set_issue(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd14, 1'b1, 2'd1, 1'b0);
        #1 check_val("r0_stall", stall, 1'b0);
        tick();
        check_val("r0_a", fwd_a_sel, 2'd0);
        check_val("r0_b", fwd_b_sel, 2'd0);
        idle(3);

        // An unused source never matches.
        set_issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2, 1'b0);
        tick();
        set_issue(1'b1, 5'd1, 1'b1, 5'd7, 1'b0, 5'd15, 1'b1, 2'd1, 1'b0);
        #1 check_val("unused_stall", stall, 1'b0);
        tick();
        check_val("unused_b", fwd_b_sel, 2'd0);
        idle(3);

        // Flush beats stall, and the flushed instruction never enters slot 0.
        set_issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 2'd2, 1'b0);
        tick();
        set_issue(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 2'd2, 1'b1);
        #1 check_val("flush_stall", stall, 1'b0);
        tick();
        check_val("flush_a", fwd_a_sel, 2'd0);
        set_issue(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 2'd1, 1'b0);
        #1 check_val("postflush_stall", stall, 1'b0);
        tick();
        check_val("postflush_a", fwd_a_sel, 2'd2);
        idle(3);

        // Two more load-use stalls, for three stall cycles in total.
        for (int n = 0; n < 2; n++) begin
            set_issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 2'd2, 1'b0);
            tick();
            set_issue(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 2'd1, 1'b0);
            #1 check_val("lu_loop_stall", stall, 1'b1);
            tick();
            tick();
            idle(3);
        end
        check_val("cnt3", stall_cycles, EXP_CNT3);

        // Reset asserted in the middle of a stall cycle.
        set_issue(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 2'd1, 1'b0);
        tick();
        set_issue(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 2'd2, 1'b0);
        tick();
        check_val("pre_rst_a", fwd_a_sel, 2'd1);
        set_issue(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd17, 1'b1, 2'd1, 1'b0);
        #1 check_val("pre_rst_stall", stall, 1'b1);
        reset_n = 1'b0;
        #1;
        check_val("midrst_stall", stall, 1'b0);
        check_val("midrst_a", fwd_a_sel, 2'd0);
        check_val("midrst_b", fwd_b_sel, 2'd0);
        check_val("midrst_cnt", stall_cycles, 16'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check_val("postrst_stall", stall, 1'b0);
        idle(2);

        // Five-slot instance: a producer ready at stage 4 causes three stalls, then select 4.
        s5_valid = 1'b1; s5_rs = 5'd1; s5_rs_used = 1'b1; s5_rd = 5'd4; s5_we = 1'b1; s5_rdy = 3'd4;
        #1 check_val("s5_prod_stall", s5_stall, 1'b0);
        tick();
        s5_rs = 5'd4; s5_rd = 5'd20; s5_rdy = 3'd1;
        for (int k = 0; k < 3; k++) begin
            #1 check_val("s5_stall", s5_stall, 1'b1);
            tick();
            check_val("s5_bubble_a", s5_fwd_a, 3'd0);
        end
        #1 check_val("s5_release", s5_stall, 1'b0);
        tick();
        check_val("s5_fwd_a", s5_fwd_a, 3'd4);
        s5_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order MIPS pipeline. It sits between decode and execute.
- Tracks in-flight register writers across STAGES post-decode slots and computes load-use and multi-cycle stalls.
- Produces registered per-operand forwarding selects for the execute-stage operand muxes.
- Generalises the fixed LW-only stall and MX/WX compare logic to any pipeline depth, any per-instruction result latency, and pipeline flush.

Parameters:
- STAGES, 3, number of post-decode slots tracked (slot 0 = X, 1 = M, 2 = W at default).
- REG_AW, 5, register index width.
- SEL_W, 2, width of forwarding select and ready-stage fields; must satisfy 2^SEL_W > STAGES.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  decode presents a valid instruction.
- issue_rs  in  REG_AW  source A register.
- issue_rs_used  in  1  source A is read.
- issue_rt  in  REG_AW  source B register.
- issue_rt_used  in  1  source B is read (ALU-reg or store data).
- issue_rd  in  REG_AW  destination register.
- issue_we  in  1  instruction writes issue_rd.
- issue_rdy_stg  in  SEL_W  stage at which the result becomes forwardable: 1 = ALU (end of X), 2 = load (end of M); range 1..STAGES-1.
- flush  in  1  squash the decode instruction (taken branch/jump).
- stall  out  1  combinational; hold fetch/decode and insert a bubble into X.
- fwd_a_sel  out  SEL_W  registered select for operand A in X: 0 = regfile, k = output of stage k (1 = MX, 2 = WX).
- fwd_b_sel  out  SEL_W  same for operand B.
- stall_cycles  out  16  stall cycle counter (see Optional Feature).

Behaviour:
- Slot array slot[0..STAGES-1], each holding {valid, rd, rdy_stg}. Every clock, slot[i+1] <= slot[i]; the last slot's content is dropped (retired).
- The regfile is write-through; a producer in slot STAGES-1 at decode time therefore needs no forwarding and is ignored for matching.
- Match rule, per source s with s_used=1 and s!=0:
  - Find the youngest (lowest i, i <= STAGES-2) slot with valid & we & rd==s.
  - Register 0 never matches.
  - Older matches are shadowed by the youngest one.
- stall = issue_valid & ~flush & (any used source's youngest match i has rdy_stg > i+1).
- Slot[0] load at each edge:
  - issue_valid & ~stall & ~flush: {1, issue_rd & we-gated, issue_rdy_stg}. An instruction with we=0 loads valid=1 with we recorded as 0.
  - stall | flush | ~issue_valid: bubble {valid=0}.
- fwd_*_sel register load at each edge:
  - Accepted issue: i+1 for the youngest match, 0 if none.
  - Otherwise: 0.
  - Latency from decode to the select being valid is 1 cycle, aligned with the instruction's X cycle.
- flush has priority over stall. A flushed instruction never stalls and never enters slot[0].
- Slots beyond 0 are not flushed; branches resolve in X, so older instructions are architecturally valid.
- Reset (async, any time, including mid-stall):
  - All slot valid bits 0.
  - fwd_a_sel = fwd_b_sel = 0.
  - stall_cycles = 0.
  - stall then evaluates 0 until new producers issue.
- Default configuration must reproduce the legacy behaviour exactly: one-cycle load-use stall, then WX forwarding; ALU-to-ALU back-to-back uses MX; distance-2 uses WX.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: stall_cycles increments by 1 on every clock edge where stall=1, saturating at 16'hFFFF; cleared only by reset.
- Undefined: counter logic is absent and stall_cycles is tied to 16'h0000.

Test Plan:
- ALU-to-ALU: issue add rd=8, then sub rs=8 next cycle -> stall=0; sub's fwd_a_sel=1 in its X cycle.
- Load-use: issue lw rd=9 (rdy_stg=2), then add rs=9 -> stall=1 for exactly 1 cycle; add then issues with fwd_a_sel=2.
- Shadowing: issue add rd=5, add rd=5, then or rs=5 rt=5 -> fwd_a_sel=fwd_b_sel=1 (youngest), never 2.
- Register zero and unused sources:
  - Issue lw rd=0, then add rs=0 -> stall=0, sel=0.
  - Issue lw rd=7, then an instruction with rt=7 and rt_used=0 -> stall=0, fwd_b_sel=0.
- Flush vs stall: lw rd=3 in slot 0, decode presents use of r3 with flush=1 -> stall=0; next cycle slot[0] valid=0.
- Reset mid-stall with HAZ_PERF_CNT_EN:
  - Three load-use stalls -> stall_cycles=3.
  - Assert reset_n=0 during the next stall -> stall, selects, and stall_cycles go to 0 immediately.
  - STAGES=5, rdy_stg=4 producer -> 3-cycle stall, then sel=4.
